// File: rtl/led_status_driver.sv
`default_nettype none
// ============================================================================
// Module      : led_status_driver
// Description : Parametrised N-channel status-LED driver. Every channel picks
//               one of four modes from its 2-bit mode field:
//                 0 - off
//                 1 - direct      (LED follows sig, one cycle late)
//                 2 - activity    (each sig edge stretched to STRETCH_CYCLES)
//                 3 - gated blink (blinks at BLINK_HZ while sig is high)
//               An optional global PWM brightness stage sits after the mode
//               selection. The final pin drive is registered and XORed with
//               the per-channel INVERT mask so active-low LEDs are handled
//               here rather than at the board top level.
//
// Optional    : `define LED_PWM_EN to add the W_PWM parameter, the bright
//               port and the free-running PWM counter. Without it the LED is
//               simply on whenever the selected mode says so.
//
// Ports       : clk     in   1        system clock
//               rst_n   in   1        asynchronous active-low reset
//               mode    in   2*N_CH   channel i mode = mode[2*i+:2]
//               sig     in   N_CH     per-channel source, synchronous to clk
//               bright  in   W_PWM    global brightness (LED_PWM_EN only)
//               led     out  N_CH     registered LED pin drive, INVERT applied
//
// Revision    : 1.0 - initial release
// ============================================================================
module led_status_driver #(
   parameter int unsigned     N_CH           = 8,
   parameter int unsigned     CLK_HZ         = 12_000_000,
   parameter int unsigned     BLINK_HZ       = 1,
   parameter int unsigned     STRETCH_CYCLES = 240_000,
   parameter logic [N_CH-1:0] INVERT         = {N_CH{1'b0}}
`ifdef LED_PWM_EN
   ,
   parameter int unsigned     W_PWM          = 4
`endif
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [2*N_CH-1:0] mode,
   input  logic [N_CH-1:0]   sig,
`ifdef LED_PWM_EN
   input  logic [W_PWM-1:0]  bright,
`endif
   output logic [N_CH-1:0]   led
);

   // -------------------------------------------------------------------------
   // Derived constants
   // -------------------------------------------------------------------------
   // Blink half-period in clk cycles. The prescaler counts 0..C_HALF-1.
   localparam int unsigned C_HALF = CLK_HZ / (2 * BLINK_HZ);
   // Prescaler width; at least one bit so the register always exists, even
   // for C_HALF == 1 where the phase toggles every cycle.
   localparam int unsigned C_PW   = (C_HALF > 1) ? $clog2(C_HALF) : 1;
   // Stretch counter must be able to hold STRETCH_CYCLES itself.
   localparam int unsigned C_SW   = (STRETCH_CYCLES > 0) ? $clog2(STRETCH_CYCLES + 1) : 1;

   localparam logic [C_PW-1:0] C_PRESC_LAST = C_PW'(C_HALF - 1);
   localparam logic [C_SW-1:0] C_STRETCH    = C_SW'(STRETCH_CYCLES);
   localparam logic [C_SW-1:0] C_CNT_ONE    = C_SW'(1);
   localparam logic [C_SW-1:0] C_CNT_ZERO   = '0;

   localparam logic [1:0] C_MODE_OFF    = 2'd0;
   localparam logic [1:0] C_MODE_DIRECT = 2'd1;
   localparam logic [1:0] C_MODE_ACT    = 2'd2;
   localparam logic [1:0] C_MODE_BLINK  = 2'd3;

   // -------------------------------------------------------------------------
   // State
   // -------------------------------------------------------------------------
   logic [N_CH-1:0] sig_q;                 // previous-cycle copy of sig
   logic [C_SW-1:0] cnt_q [N_CH];          // per-channel activity stretch
   logic [C_SW-1:0] cnt_d [N_CH];
   logic [C_PW-1:0] presc_q, presc_d;      // shared blink prescaler
   logic            phase_q, phase_d;      // shared blink phase
   logic [N_CH-1:0] led_q, led_d;          // registered pin drive

`ifdef LED_PWM_EN
   logic [W_PWM-1:0] pwm_cnt_q, pwm_cnt_d; // free-running PWM counter
`endif

   // -------------------------------------------------------------------------
   // Combinational helpers
   // -------------------------------------------------------------------------
   logic [N_CH-1:0] edge_det;  // any transition of sig since last cycle
   logic [N_CH-1:0] on_w;      // logical on per channel, before PWM gating
   logic [N_CH-1:0] on_gated;  // logical on after the brightness stage
   logic            pwm_en_w;  // global PWM gate for this cycle

   // Rising and falling edges both count as activity.
   always_comb begin
      edge_det = sig ^ sig_q;
   end

   // Blink prescaler: free-running and shared by all channels. It is not
   // resynchronised by mode changes, so all blinking channels stay in step.
   always_comb begin
      presc_d = presc_q;
      phase_d = phase_q;
      if (presc_q == C_PRESC_LAST) begin
         presc_d = '0;
         phase_d = ~phase_q;
      end else begin
         presc_d = presc_q + C_PW'(1);
      end
   end

   // Stretch counters run in every mode. That way a channel switched into
   // activity mode immediately shows any edge seen in the last few cycles.
   always_comb begin
      for (int i = 0; i < N_CH; i++) begin
         cnt_d[i] = cnt_q[i];
         if (edge_det[i]) begin
            // Retrigger: a new edge always reloads, extending the on-time.
            cnt_d[i] = C_STRETCH;
         end else if (cnt_q[i] != C_CNT_ZERO) begin
            cnt_d[i] = cnt_q[i] - C_CNT_ONE;
         end
      end
   end

   // Per-channel mode selection.
   // Activity mode: the edge term covers the first on-cycle (the counter is
   // only loaded at that edge), and "cnt > 1" covers the remaining
   // STRETCH_CYCLES-1 cycles, so an isolated edge yields exactly
   // STRETCH_CYCLES cycles of on-time.
   always_comb begin
      on_w = '0;
      for (int i = 0; i < N_CH; i++) begin
         case (mode[2*i +: 2])
            C_MODE_OFF:    on_w[i] = 1'b0;
            C_MODE_DIRECT: on_w[i] = sig[i];
            C_MODE_ACT:    on_w[i] = edge_det[i] | (cnt_q[i] > C_CNT_ONE);
            C_MODE_BLINK:  on_w[i] = sig[i] & phase_q;
            default:       on_w[i] = 1'b0;
         endcase
      end
   end

`ifdef LED_PWM_EN
   // Brightness stage. All-ones bright forces the gate open so full
   // brightness is truly 100% instead of (2^W_PWM-1)/2^W_PWM.
   always_comb begin
      pwm_cnt_d = pwm_cnt_q + W_PWM'(1);
      pwm_en_w  = (&bright) | (pwm_cnt_q < bright);
   end
`else
   always_comb begin
      pwm_en_w = 1'b1;
   end
`endif

   always_comb begin
      on_gated = on_w & {N_CH{pwm_en_w}};
      led_d    = on_gated ^ INVERT;
   end

   // -------------------------------------------------------------------------
   // Registers
   // -------------------------------------------------------------------------
   // Reset drives every LED to its logical-off level straight away, without
   // waiting for a clock edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sig_q   <= '0;
         presc_q <= '0;
         phase_q <= 1'b0;
         led_q   <= INVERT;
         for (int i = 0; i < N_CH; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         sig_q   <= sig;
         presc_q <= presc_d;
         phase_q <= phase_d;
         led_q   <= led_d;
         for (int i = 0; i < N_CH; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

`ifdef LED_PWM_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pwm_cnt_q <= '0;
      end else begin
         pwm_cnt_q <= pwm_cnt_d;
      end
   end
`endif

   assign led = led_q;

endmodule
`default_nettype wire

// File: tb/tb_led_status_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_led_status_driver
// Description : Self-checking bench for led_status_driver with N_CH=4,
//               CLK_HZ=16, BLINK_HZ=2 (half-period 4), STRETCH_CYCLES=5,
//               INVERT=4'b1000. A cycle-level model derived from the mode
//               rules is compared against led after every clock edge; the
//               directed sequences add hand-computed literal checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_led_status_driver;

   localparam int        N_CH    = 4;
   localparam int        HALF    = 4;
   localparam int        STRETCH = 5;
   localparam logic [3:0] INV    = 4'b1000;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] mode = 8'hFF;
   logic [3:0] sig  = 4'hF;
   logic [3:0] led;
`ifdef LED_PWM_EN
   logic [3:0] bright = 4'hF;
`endif

   int checks = 0;
   int errors = 0;

   led_status_driver #(
      .N_CH           (4),
      .CLK_HZ         (16),
      .BLINK_HZ       (2),
      .STRETCH_CYCLES (5),
      .INVERT         (4'b1000)
`ifdef LED_PWM_EN
      ,
      .W_PWM          (4)
`endif
   ) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .mode   (mode),
      .sig    (sig),
`ifdef LED_PWM_EN
      .bright (bright),
`endif
      .led    (led)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------------
   // Reference model: e counts clock edges since reset release. Activity is
   // "an edge within the last STRETCH edges", blink phase is (e/HALF) odd,
   // and PWM is the edge count modulo 16.
   // ---------------------------------------------------------------------
   int         e = 0;
   logic [3:0] prev = 4'h0;
   int         last_e [4] = '{-1000, -1000, -1000, -1000};
   logic [3:0] expv = INV;

   initial begin
      forever begin
         @(posedge clk);
         if (!rst_n) begin
            e      = 0;
            prev   = 4'h0;
            last_e = '{-1000, -1000, -1000, -1000};
            expv   = INV;
         end else begin
            for (int i = 0; i < N_CH; i++) begin
               logic on;
               logic [1:0] md;
               if (sig[i] != prev[i]) last_e[i] = e;
               md = mode[2*i +: 2];
               case (md)
                  2'd0: on = 1'b0;
                  2'd1: on = sig[i];
                  2'd2: on = ((e - last_e[i]) < STRETCH);
                  default: on = sig[i] && (((e / HALF) % 2) == 1);
               endcase
`ifdef LED_PWM_EN
               if (!((bright == 4'hF) || ((e % 16) < int'(bright)))) on = 1'b0;
`endif
               expv[i] = on ^ INV[i];
            end
            prev = sig;
            e++;
         end
         #1;
         check("led_model", {28'd0, led}, {28'd0, expv});
      end
   end

   task automatic tick(input int n = 1);
      for (int k = 0; k < n; k++) @(negedge clk);
   endtask

   int cnt;

   initial begin
      // 1. Reset with everything requesting on.
      tick(3);
      check("reset_led", {28'd0, led}, 32'h8);
      rst_n = 1'b1;
      #1;
      check("release_led", {28'd0, led}, 32'h8);
      tick();
      // First update: all blink mode, phase still 0 -> all off.
      check("first_update", {28'd0, led}, 32'h8);
      mode = 8'h00;
      sig  = 4'h0;
      tick(8);

      // 2. Direct mode on ch0 and inverted ch3.
      mode = 8'h41;
      tick();
      check("direct_idle", {28'd0, led}, 32'h8);
      sig[0] = 1'b1;
      tick();
      check("direct_ch0_hi", {31'd0, led[0]}, 32'd1);
      sig[0] = 1'b0;
      tick();
      check("direct_ch0_lo", {31'd0, led[0]}, 32'd0);
      sig[3] = 1'b1;
      tick();
      check("direct_ch3_inv", {31'd0, led[3]}, 32'd0);
      sig[3] = 1'b0;
      tick(2);

      // 3. Activity on ch1: isolated edge, then retrigger.
      mode = 8'h49;
      tick(2);
      sig[1] = 1'b1;
      for (int i = 1; i <= 6; i++) begin
         tick();
         check("act_single", {31'd0, led[1]}, {31'd0, (i <= 5)});
      end
      tick(3);
      sig[1] = 1'b0;
      for (int i = 1; i <= 9; i++) begin
         tick();
         check("act_retrig", {31'd0, led[1]}, {31'd0, (i <= 8)});
         if (i == 3) sig[1] = 1'b1;
      end

      // 4. Blink on ch2.
      mode   = 8'h79;
      sig[2] = 1'b1;
      tick();
      cnt = 0;
      for (int i = 0; i < 16; i++) begin
         tick();
         cnt += int'(led[2]);
      end
      check("blink_duty16", cnt, 8);
      cnt = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         cnt += int'(led[2]);
      end
      check("blink_duty8", cnt, 4);
      sig[2] = 1'b0;
      tick();
      cnt = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         cnt += int'(led[2]);
      end
      check("blink_gated_off", cnt, 0);

      // 5a. Edge while off, switch to activity two cycles later.
      mode = 8'h71;
      tick(7);
      sig[1] = 1'b0;
      tick();
      check("switch_off1", {31'd0, led[1]}, 32'd0);
      tick();
      check("switch_off2", {31'd0, led[1]}, 32'd0);
      mode = 8'h79;
      cnt  = 0;
      for (int i = 3; i <= 6; i++) begin
         tick();
         cnt += int'(led[1]);
         check("switch_seq", {31'd0, led[1]}, {31'd0, (i <= 5)});
      end
      check("switch_count", cnt, 3);

      // 5b. Asynchronous reset in the middle of a stretch.
      tick(3);
      sig[1] = 1'b1;
      tick(2);
      check("pre_reset_on", {31'd0, led[1]}, 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_reset", {28'd0, led}, 32'h8);
      tick(2);
      rst_n = 1'b1;
      // sig[1] still high against cleared history -> fresh edge.
      tick();
      check("post_reset_led", {28'd0, led}, 32'hA);
      cnt = 1;
      for (int i = 0; i < 5; i++) begin
         tick();
         cnt += int'(led[1]);
      end
      check("post_reset_stretch", cnt, 5);

`ifdef LED_PWM_EN
      // 6. Brightness on direct-mode channels.
      mode   = 8'h55;
      sig    = 4'hF;
      bright = 4'd4;
      tick();
      cnt = 0;
      for (int i = 0; i < 16; i++) begin
         tick();
         cnt += int'(led[0]);
      end
      check("pwm_bright4", cnt, 4);
      bright = 4'd0;
      tick();
      cnt = 0;
      for (int i = 0; i < 16; i++) begin
         tick();
         cnt += int'(led[0]);
      end
      check("pwm_bright0", cnt, 0);
      bright = 4'd15;
      tick();
      cnt = 0;
      for (int i = 0; i < 16; i++) begin
         tick();
         cnt += int'(led[0]);
      end
      check("pwm_bright15", cnt, 16);
`endif

      tick(2);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
